// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forward selects,
// FSM state type and the hard-wired zero register number.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_LD  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MUL = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forward select for one ID source register; the nearest producer
// wins, and r0 or an unused operand always reads the register file.
module fwd_sel
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_rn,
    input  logic       src_use,
    input  logic [4:0] exe_rn,
    input  logic       exe_wreg,
    input  logic       exe_m2reg,
    input  logic [4:0] mem_rn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    output logic [1:0] fwd
);

    // priority select across EXE ALU, MEM ALU and MEM load data
    always_comb begin
        fwd = FWD_REG;
        if (!src_use || (src_rn == REG_ZERO)) begin
            fwd = FWD_REG;
        end else if (exe_wreg && !exe_m2reg && (exe_rn == src_rn)) begin
            fwd = FWD_EXE;
        end else if (mem_wreg && !mem_m2reg && (mem_rn == src_rn)) begin
            fwd = FWD_MEM;
        end else if (mem_wreg && mem_m2reg && (mem_rn == src_rn)) begin
            fwd = FWD_LD;
        end else begin
            fwd = FWD_REG;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle multiply hold in
// EXE, operand forwarding and IF/ID flush on taken branches.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_mul,
    input  logic             id_branch_tk,
    input  logic [4:0]       exe_rn,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_en,
    output logic             idexe_bubble,
    output logic             exemem_bubble,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mul_busy,
    output logic             mul_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MC_W = $clog2(MUL_LAT);

    state_e            state_q, state_d;
    logic [MC_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [1:0]        fwda_s, fwdb_s;
    logic              lu_hz_s;

    fwd_sel u_fwd_a (
        .src_rn(id_rs), .src_use(id_use_rs),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .fwd(fwda_s)
    );

    fwd_sel u_fwd_b (
        .src_rn(id_rt), .src_use(id_use_rt),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .fwd(fwdb_s)
    );

    assign lu_hz_s = exe_wreg && exe_m2reg && (exe_rn != REG_ZERO) &&
                     ((id_use_rs && (id_rs == exe_rn)) ||
                      (id_use_rt && (id_rt == exe_rn)));

    // next-state, multiply countdown and pipeline control outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idexe_en      = 1'b1;
        idexe_bubble  = 1'b0;
        exemem_bubble = 1'b0;
        mul_busy      = 1'b0;
        mul_done      = 1'b0;
        fwda          = fwda_s;
        fwdb          = fwdb_s;
        case (state_q)
            ST_RUN: begin
                if (lu_hz_s) begin
                    pc_en        = 1'b0;
                    ifid_en      = 1'b0;
                    idexe_bubble = 1'b1;
                end else if (id_mul) begin
                    state_d = ST_MUL;
                    cnt_d   = MC_W'(MUL_LAT - 2);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_MUL: begin
                pc_en         = 1'b0;
                ifid_en       = 1'b0;
                idexe_en      = 1'b0;
                exemem_bubble = 1'b1;
                mul_busy      = 1'b1;
                if (cnt_q == '0) begin
                    mul_done      = 1'b1;
                    exemem_bubble = 1'b0;
                    state_d       = ST_RUN;
                end else begin
                    cnt_d = cnt_q - MC_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        // a stalled branch is simply re-presented once ID advances
        ifid_flush = id_branch_tk && pc_en;
        if (!clrn) begin
            pc_en         = 1'b1;
            ifid_en       = 1'b1;
            idexe_en      = 1'b1;
            idexe_bubble  = 1'b0;
            exemem_bubble = 1'b0;
            ifid_flush    = 1'b0;
            mul_busy      = 1'b0;
            mul_done      = 1'b0;
            fwda          = FWD_REG;
            fwdb          = FWD_REG;
        end else begin
            ifid_flush = id_branch_tk && pc_en;
        end
    end

    // saturating count of cycles the PC is held
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // state, multiply counter and stall counter registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (MUL_LAT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic [4:0] id_rs, id_rt, exe_rn, mem_rn;
    logic       id_use_rs, id_use_rt, id_mul, id_branch_tk;
    logic       exe_wreg, exe_m2reg, mem_wreg, mem_m2reg;
    logic       pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, exemem_bubble;
    logic [1:0] fwda, fwdb;
    logic       mul_busy, mul_done;
    logic [3:0] stall_cnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .clrn(clrn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_mul(id_mul), .id_branch_tk(id_branch_tk),
        .exe_rn(exe_rn), .exe_wreg(exe_wreg), .exe_m2reg(exe_m2reg),
        .mem_rn(mem_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idexe_en(idexe_en), .idexe_bubble(idexe_bubble), .exemem_bubble(exemem_bubble),
        .fwda(fwda), .fwdb(fwdb), .mul_busy(mul_busy), .mul_done(mul_done),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic        use_rs, use_rt, br;
        logic [4:0]  ern;
        logic        ewreg, em2reg;
        logic [4:0]  mrn;
        logic        mwreg, mm2reg;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];

    // {pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, exemem_bubble, mul_busy, mul_done, fwda, fwdb}
    function automatic logic [11:0] outs();
        return {pc_en, ifid_en, ifid_flush, idexe_en, idexe_bubble, exemem_bubble,
                mul_busy, mul_done, fwda, fwdb};
    endfunction

    function automatic logic [11:0] run_exp(logic pc, logic fl, logic bub,
                                            logic [1:0] fa, logic [1:0] fb);
        return {pc, pc, fl, 1'b1, bub, 1'b0, 1'b0, 1'b0, fa, fb};
    endfunction

    function automatic vec_t mk(logic [4:0] rs, logic [4:0] rt, logic urs, logic urt, logic br,
                                logic [4:0] ern, logic ew, logic em,
                                logic [4:0] mrn, logic mw, logic mm, logic [11:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.use_rs = urs; v.use_rt = urt; v.br = br;
        v.ern = ern; v.ewreg = ew; v.em2reg = em;
        v.mrn = mrn; v.mwreg = mw; v.mm2reg = mm; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_mul = 1'b0; id_branch_tk = 1'b0;
        exe_rn = 5'd0; exe_wreg = 1'b0; exe_m2reg = 1'b0;
        mem_rn = 5'd0; mem_wreg = 1'b0; mem_m2reg = 1'b0;
    endtask

    task automatic apply(vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
        id_branch_tk = v.br; id_mul = 1'b0;
        exe_rn = v.ern; exe_wreg = v.ewreg; exe_m2reg = v.em2reg;
        mem_rn = v.mrn; mem_wreg = v.mwreg; mem_m2reg = v.mm2reg;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clrn = 1'b0;
        drive_idle();
        @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b0;
        drive_idle();
        id_rs = 5'd3; id_use_rs = 1'b1; exe_rn = 5'd3; exe_wreg = 1'b1; exe_m2reg = 1'b1;
        #12;
        check("reset_outs", 16'(outs()), 16'(run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd0)));
        check("reset_stall_cnt", 16'(stall_cnt), 16'd0);
        drive_idle();
        @(negedge clk);
        clrn = 1'b1;

        vecs[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        vecs[1]  = mk(5'd1,  5'd5,  1'b1, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd1));
        vecs[2]  = mk(5'd1,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        vecs[3]  = mk(5'd5,  5'd2,  1'b1, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd2, 2'd0));
        vecs[4]  = mk(5'd9,  5'd9,  1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd9,  1'b1, 1'b1, run_exp(1'b1, 1'b0, 1'b0, 2'd3, 2'd0));
        vecs[5]  = mk(5'd3,  5'd0,  1'b1, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, run_exp(1'b0, 1'b0, 1'b1, 2'd0, 2'd0));
        vecs[6]  = mk(5'd2,  5'd4,  1'b1, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 5'd4,  1'b1, 1'b1, run_exp(1'b1, 1'b1, 1'b0, 2'd0, 2'd3));
        vecs[7]  = mk(5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        vecs[8]  = mk(5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1, run_exp(1'b1, 1'b0, 1'b0, 2'd0, 2'd0));
        vecs[9]  = mk(5'd4,  5'd4,  1'b1, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 5'd4,  1'b1, 1'b0, run_exp(1'b1, 1'b0, 1'b0, 2'd2, 2'd2));
        vecs[10] = mk(5'd1,  5'd6,  1'b1, 1'b1, 1'b0, 5'd6,  1'b1, 1'b1, 5'd1,  1'b1, 1'b0, run_exp(1'b0, 1'b0, 1'b1, 2'd2, 2'd0));
        vecs[11] = mk(5'd11, 5'd11, 1'b1, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1, run_exp(1'b1, 1'b0, 1'b0, 2'd1, 2'd1));

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #2;
            check($sformatf("vec%0d", i), 16'(outs()), 16'(vecs[i].exp));
        end
        @(negedge clk);
        drive_idle();
        #2;
        check("table_stall_cnt", 16'(stall_cnt), 16'd2);

        // load-use: one stall cycle, then load data forwarded from MEM
        do_reset();
        id_rs = 5'd3; id_use_rs = 1'b1; exe_rn = 5'd3; exe_wreg = 1'b1; exe_m2reg = 1'b1;
        #2;
        check("lu_stall", 16'({pc_en, ifid_en, idexe_bubble, idexe_en}), 16'(4'b0011));
        @(negedge clk);
        exe_rn = 5'd0; exe_wreg = 1'b0; exe_m2reg = 1'b0;
        mem_rn = 5'd3; mem_wreg = 1'b1; mem_m2reg = 1'b1;
        #2;
        check("lu_release_pc", 16'({pc_en, idexe_bubble}), 16'(2'b10));
        check("lu_fwda", 16'(fwda), 16'd3);
        check("lu_stall_cnt", 16'(stall_cnt), 16'd1);

        // multiply: issue in RUN, then three MUL cycles
        do_reset();
        id_mul = 1'b1;
        #2;
        check("mul_issue", 16'({pc_en, mul_busy, idexe_en}), 16'(3'b101));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_mul = 1'b0;
            #2;
            check($sformatf("mul_cyc%0d", i),
                  16'({pc_en, ifid_en, idexe_en, mul_busy, mul_done, exemem_bubble}),
                  16'({1'b0, 1'b0, 1'b0, 1'b1, (i == 2), (i != 2)}));
        end
        @(negedge clk);
        #2;
        check("mul_end", 16'({pc_en, mul_busy, mul_done}), 16'(3'b100));
        check("mul_stall_cnt", 16'(stall_cnt), 16'd3);

        // load-use plus multiply plus taken branch
        do_reset();
        id_rs = 5'd3; id_use_rs = 1'b1; id_mul = 1'b1; id_branch_tk = 1'b1;
        exe_rn = 5'd3; exe_wreg = 1'b1; exe_m2reg = 1'b1;
        #2;
        check("combo_stall", 16'({pc_en, ifid_flush, mul_busy, idexe_bubble}), 16'(4'b0001));
        @(negedge clk);
        exe_rn = 5'd0; exe_wreg = 1'b0; exe_m2reg = 1'b0;
        mem_rn = 5'd3; mem_wreg = 1'b1; mem_m2reg = 1'b1;
        #2;
        check("combo_release", 16'({pc_en, ifid_flush, mul_busy, idexe_bubble}), 16'(4'b1100));
        @(negedge clk);
        id_mul = 1'b0; id_branch_tk = 1'b0;
        #2;
        check("combo_mul_busy", 16'({mul_busy, pc_en}), 16'(2'b10));

        // reset during the second MUL cycle aborts the multiply
        do_reset();
        id_mul = 1'b1;
        @(negedge clk);
        id_mul = 1'b0;
        @(negedge clk);
        #2;
        check("abort_pre", 16'({mul_busy, pc_en, mul_done}), 16'(3'b100));
        clrn = 1'b0;
        #1;
        check("abort_now", 16'({mul_busy, pc_en}), 16'(2'b01));
        check("abort_stall_cnt", 16'(stall_cnt), 16'd0);
        @(negedge clk);
        clrn = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                #2;
                if (mul_done || mul_busy) seen = 1'b1;
            end
            check("abort_no_done", 16'(seen), 16'd0);
        end

        // stall counter saturation with a held load-use hazard
        do_reset();
        id_rs = 5'd7; id_use_rs = 1'b1; exe_rn = 5'd7; exe_wreg = 1'b1; exe_m2reg = 1'b1;
        for (int i = 0; i < 10; i++) @(negedge clk);
        #2;
        check("sat_mid", 16'(stall_cnt), 16'd10);
        for (int i = 0; i < 11; i++) @(negedge clk);
        #2;
        check("sat_hold", 16'(stall_cnt), 16'hF);
        drive_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
